// File: rtl/decode_decompress_if.sv
// Stream-in / pair-out bus of the coefficient decoder: packed compressed words in,
// decompressed coefficient pairs and run status out.
interface decode_decompress_if;
  logic        set;
  logic        start;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [6:0]  addr_out;
  logic [15:0] dout_a;
  logic [15:0] dout_b;
  logic        dout_valid;
  logic [3:0]  status;

  modport master (
    output set, start, din, din_valid,
    input  din_ready, addr_out, dout_a, dout_b, dout_valid, status
  );

  modport slave (
    input  set, start, din, din_valid,
    output din_ready, addr_out, dout_a, dout_b, dout_valid, status
  );
endinterface

// File: rtl/decode_decompress.sv
// Unpacks an LSB-first stream of DD-bit compressed coefficients and decompresses
// each pair as y = (x*3329 + 2^(DD-1)) >> DD through a three-register pipeline.
module decode_decompress #(
  parameter int DD = 4
) (
  input logic                 clk,
  input logic                 reset,
  decode_decompress_if.slave  bus
);
  localparam int PW     = 2 * DD;
  localparam int BW     = 2 * DD + 15;
  localparam int NWORDS = 16 * DD;
  localparam int MW     = DD + 13;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   bitbuf_reg, bitbuf_next, bitbuf_shift;
  logic [5:0]      count_reg, count_next, count_after;
  logic [7:0]      word_cnt_reg;
  logic [6:0]      pair_cnt_reg;
  logic [PW-1:0]   s1_data_reg;
  logic            s1_valid_reg;
  logic [1:0][15:0] s2_data_reg;
  logic            s2_valid_reg;
  logic [15:0]     dout_a_reg, dout_b_reg;
  logic            dout_valid_reg;
  logic [6:0]      addr_out_reg;
  logic            extract, accept, ready, clear;
  logic [15:0]     y [2];

  // Extraction frees space first, so the incoming word lands right after the
  // bits that survive the shift.
  always_comb begin
    extract      = (count_reg >= 6'(PW));
    count_after  = extract ? (count_reg - 6'(PW)) : count_reg;
    bitbuf_shift = extract ? (bitbuf_reg >> PW) : bitbuf_reg;
    ready        = (state_reg == RUN) && (count_after <= 6'(PW - 1)) &&
                   (word_cnt_reg < 8'(NWORDS));
    accept       = bus.set && bus.din_valid && ready;
    bitbuf_next  = bitbuf_shift;
    count_next   = count_after;
    if (accept) begin
      bitbuf_next = bitbuf_shift | (BW'(bus.din) << count_after);
      count_next  = count_after + 6'd16;
    end
  end

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (accept && (word_cnt_reg == 8'(NWORDS - 1))) state_next = FLUSH;
      end
      FLUSH: begin
        if (dout_valid_reg && (addr_out_reg == 7'd127)) state_next = DONE;
      end
      DONE: begin
        if (!bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (bus.set) begin
      state_reg <= state_next;
    end
  end

  // Product kept at DD+13 bits so the rounding add can never wrap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DD-1:0] x;
    logic [MW-1:0] prod;
    assign x    = s1_data_reg[gi*DD +: DD];
    assign prod = MW'(x) * MW'(3329) + MW'(1 << (DD - 1));
    assign y[gi] = 16'(prod >> DD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitbuf_reg     <= '0;
      count_reg      <= '0;
      word_cnt_reg   <= '0;
      pair_cnt_reg   <= '0;
      s1_data_reg    <= '0;
      s1_valid_reg   <= 1'b0;
      s2_data_reg    <= '0;
      s2_valid_reg   <= 1'b0;
      dout_a_reg     <= '0;
      dout_b_reg     <= '0;
      dout_valid_reg <= 1'b0;
      addr_out_reg   <= '0;
    end else if (bus.set) begin
      if (clear) begin
        bitbuf_reg     <= '0;
        count_reg      <= '0;
        word_cnt_reg   <= '0;
        pair_cnt_reg   <= '0;
        s1_valid_reg   <= 1'b0;
        s2_valid_reg   <= 1'b0;
        dout_valid_reg <= 1'b0;
        addr_out_reg   <= '0;
      end else begin
        bitbuf_reg <= bitbuf_next;
        count_reg  <= count_next;
        if (accept) word_cnt_reg <= word_cnt_reg + 8'd1;

        s1_valid_reg <= extract;
        if (extract) s1_data_reg <= bitbuf_reg[PW-1:0];

        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) s2_data_reg <= {y[1], y[0]};

        dout_valid_reg <= s2_valid_reg;
        if (s2_valid_reg) begin
          dout_a_reg   <= s2_data_reg[0];
          dout_b_reg   <= s2_data_reg[1];
          addr_out_reg <= pair_cnt_reg;
          pair_cnt_reg <= pair_cnt_reg + 7'd1;
        end
      end
    end
  end

  always_comb begin
    bus.status = 4'd0;
    case (state_reg)
      RUN, FLUSH: bus.status = 4'd1;
      DONE:       bus.status = 4'd5;
      default:    bus.status = 4'd0;
    endcase
  end

  assign bus.din_ready  = ready;
  assign bus.dout_a     = dout_a_reg;
  assign bus.dout_b     = dout_b_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.addr_out   = addr_out_reg;
endmodule

// File: tb/tb_decode_decompress.sv
// Drives a DD=4 and a DD=10 decoder with packed streams and scores every output
// pair against an expectation queue filled when the stream is built.
module tb_decode_decompress;
  logic clk = 1'b0;
  logic reset4 = 1'b0;
  logic reset10 = 1'b0;
  always #5 clk = ~clk;

  decode_decompress_if ifc4();
  decode_decompress_if ifc10();

  decode_decompress #(.DD(4))  u_dut4  (.clk(clk), .reset(reset4),  .bus(ifc4.slave));
  decode_decompress #(.DD(10)) u_dut10 (.clk(clk), .reset(reset10), .bus(ifc10.slave));

  typedef struct { int addr; int a; int b; } pair_t;
  pair_t q4[$];
  pair_t q10[$];
  int errors = 0;
  int checks = 0;
  logic [15:0] words [0:159];

  function automatic int decomp(input int x, input int dd);
    return (x * 3329 + (1 << (dd - 1))) >> dd;
  endfunction

  function automatic logic [3:0] get_status(input int dd);
    return (dd == 4) ? ifc4.status : ifc10.status;
  endfunction

  function automatic logic get_ready(input int dd);
    return (dd == 4) ? ifc4.din_ready : ifc10.din_ready;
  endfunction

  task automatic drive(input int dd, input logic [15:0] w, input logic v);
    if (dd == 4) begin ifc4.din = w;  ifc4.din_valid = v;  end
    else         begin ifc10.din = w; ifc10.din_valid = v; end
  endtask

  task automatic set_start(input int dd, input logic s);
    if (dd == 4) ifc4.start = s; else ifc10.start = s;
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (ifc4.dout_valid === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL dd4_unexpected_pair got addr=%0d a=%0d b=%0d required none",
                 ifc4.addr_out, ifc4.dout_a, ifc4.dout_b);
      end else begin
        e = q4.pop_front();
        if (ifc4.addr_out !== 7'(e.addr) || ifc4.dout_a !== 16'(e.a) || ifc4.dout_b !== 16'(e.b)) begin
          errors++;
          $display("FAIL dd4_pair got addr=%0d a=%0d b=%0d required addr=%0d a=%0d b=%0d",
                   ifc4.addr_out, ifc4.dout_a, ifc4.dout_b, e.addr, e.a, e.b);
        end else $display("dd4 pair %0d ok (%0d,%0d)", e.addr, e.a, e.b);
      end
    end
  end

  always @(negedge clk) begin
    pair_t e;
    if (ifc10.dout_valid === 1'b1) begin
      checks++;
      if (q10.size() == 0) begin
        errors++;
        $display("FAIL dd10_unexpected_pair got addr=%0d a=%0d b=%0d required none",
                 ifc10.addr_out, ifc10.dout_a, ifc10.dout_b);
      end else begin
        e = q10.pop_front();
        if (ifc10.addr_out !== 7'(e.addr) || ifc10.dout_a !== 16'(e.a) || ifc10.dout_b !== 16'(e.b)) begin
          errors++;
          $display("FAIL dd10_pair got addr=%0d a=%0d b=%0d required addr=%0d a=%0d b=%0d",
                   ifc10.addr_out, ifc10.dout_a, ifc10.dout_b, e.addr, e.a, e.b);
        end else $display("dd10 pair %0d ok (%0d,%0d)", e.addr, e.a, e.b);
      end
    end
  end

  // Streams words[] into one DUT; pairs from first_model_pair on are predicted
  // here, earlier ones are pushed by the caller as fixed constants.
  task automatic run_poly(input int dd, input bit gaps, input int abort_after,
                          input int first_model_pair, input int drop_start_at);
    int nwords, i, cyc, xa, xb, qs;
    logic r;
    pair_t p;
    logic [2559:0] stream;
    nwords = 16 * dd;
    stream = '0;
    for (int w = 0; w < nwords; w++) stream[w*16 +: 16] = words[w];
    for (int k = first_model_pair; k < 128; k++) begin
      xa = 0; xb = 0;
      for (int b = 0; b < dd; b++) begin
        xa = xa | (int'(stream[(2*k)*dd + b]) << b);
        xb = xb | (int'(stream[(2*k+1)*dd + b]) << b);
      end
      p.addr = k; p.a = decomp(xa, dd); p.b = decomp(xb, dd);
      if (dd == 4) q4.push_back(p); else q10.push_back(p);
    end
    @(negedge clk);
    set_start(dd, 1'b1);
    i = 0; cyc = 0;
    while (i < nwords && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (abort_after > 0 && i >= abort_after) break;
      if (i == drop_start_at) set_start(dd, 1'b0);
      r = get_ready(dd);
      if (gaps && $urandom_range(0, 2) == 0) drive(dd, 16'($urandom), 1'b0);
      else if (r) begin drive(dd, words[i], 1'b1); i++; end
      else drive(dd, 16'($urandom), 1'b1);   // refused word must not be consumed
    end
    if (abort_after > 0) return;
    checks++;
    if (i != nwords) begin
      errors++;
      $display("FAIL dd%0d_word_timeout got words=%0d required %0d", dd, i, nwords);
    end
    @(negedge clk);
    drive(dd, 16'h0, 1'b0);
    set_start(dd, 1'b1);
    checks++;
    if (get_ready(dd) !== 1'b0) begin
      errors++;
      $display("FAIL dd%0d_ready_after_last got %b required 0", dd, get_ready(dd));
    end
    cyc = 0;
    while (get_status(dd) !== 4'd5 && cyc < 1000) begin @(negedge clk); cyc++; end
    checks++;
    if (get_status(dd) !== 4'd5) begin
      errors++;
      $display("FAIL dd%0d_done got status=%0d required 5", dd, get_status(dd));
    end
    qs = (dd == 4) ? q4.size() : q10.size();
    checks++;
    if (qs != 0) begin
      errors++;
      $display("FAIL dd%0d_pairs_missing got %0d outstanding required 0", dd, qs);
    end
    checks++;
    if (((dd == 4) ? ifc4.addr_out : ifc10.addr_out) !== 7'd127) begin
      errors++;
      $display("FAIL dd%0d_last_addr got %0d required 127", dd,
               (dd == 4) ? ifc4.addr_out : ifc10.addr_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (get_status(dd) !== 4'd5) begin
      errors++;
      $display("FAIL dd%0d_done_hold got status=%0d required 5", dd, get_status(dd));
    end
    set_start(dd, 1'b0);
    @(negedge clk);
    checks++;
    if (get_status(dd) !== 4'd0) begin
      errors++;
      $display("FAIL dd%0d_back_to_idle got status=%0d required 0", dd, get_status(dd));
    end
    $display("dd%0d polynomial complete", dd);
  endtask

  task automatic test_reset();
    ifc4.set = 1'b0;  ifc4.start = 1'b0;  ifc4.din = '0;  ifc4.din_valid = 1'b0;
    ifc10.set = 1'b0; ifc10.start = 1'b0; ifc10.din = '0; ifc10.din_valid = 1'b0;
    #2 reset4 = 1'b1; reset10 = 1'b1;
    #1;
    checks++;
    if (ifc4.status !== 4'd0 || ifc4.din_ready !== 1'b0 || ifc4.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got status=%0d ready=%b valid=%b required 0 0 0",
               ifc4.status, ifc4.din_ready, ifc4.dout_valid);
    end
    checks++;
    if (ifc4.addr_out !== 7'd0 || ifc4.dout_a !== 16'd0 || ifc4.dout_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d a=%0d b=%0d required 0 0 0",
               ifc4.addr_out, ifc4.dout_a, ifc4.dout_b);
    end
    checks++;
    if (ifc10.status !== 4'd0 || ifc10.din_ready !== 1'b0 || ifc10.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dd10 got status=%0d ready=%b valid=%b required 0 0 0",
               ifc10.status, ifc10.din_ready, ifc10.dout_valid);
    end
    $display("reset check done");
    repeat (2) @(negedge clk);
    reset4 = 1'b0; reset10 = 1'b0;
    ifc10.set = 1'b1;
  endtask

  task automatic test_set_gating();
    ifc4.set = 1'b0; ifc4.start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc4.status !== 4'd0 || ifc4.din_ready !== 1'b0) begin
      errors++;
      $display("FAIL set_gating got status=%0d ready=%b required 0 0", ifc4.status, ifc4.din_ready);
    end
    ifc4.start = 1'b0; ifc4.set = 1'b1;
    @(negedge clk);
    $display("set gating check done");
  endtask

  task automatic test_all_ones_dd4();
    pair_t p;
    for (int w = 0; w < 64; w++) words[w] = 16'hFFFF;
    for (int k = 0; k < 128; k++) begin p.addr = k; p.a = 3121; p.b = 3121; q4.push_back(p); end
    run_poly(4, 1'b0, 0, 128, -1);
  endtask

  task automatic test_pattern_dd4();
    pair_t p;
    words[0] = 16'h2110;
    words[1] = 16'h00FF;
    for (int w = 2; w < 64; w++) words[w] = 16'($urandom);
    p.addr = 0; p.a = 0;    p.b = 208;  q4.push_back(p);
    p.addr = 1; p.a = 208;  p.b = 416;  q4.push_back(p);
    p.addr = 2; p.a = 3121; p.b = 3121; q4.push_back(p);
    p.addr = 3; p.a = 0;    p.b = 0;    q4.push_back(p);
    run_poly(4, 1'b1, 0, 4, -1);
  endtask

  task automatic load_dd10_pattern();
    logic [2559:0] s;
    int pat [4];
    int v;
    pat = '{1, 512, 1023, 0};
    s = '0;
    for (int c = 0; c < 256; c++) begin
      v = pat[c % 4];
      for (int b = 0; b < 10; b++) s[c*10 + b] = v[b];
    end
    for (int w = 0; w < 160; w++) words[w] = s[w*16 +: 16];
  endtask

  task automatic push_dd10_pattern();
    pair_t p;
    for (int k = 0; k < 128; k++) begin
      p.addr = k;
      if (k % 2 == 0) begin p.a = 3;    p.b = 1665; end
      else            begin p.a = 3326; p.b = 0;    end
      q10.push_back(p);
    end
  endtask

  task automatic test_dd10_back_to_back();
    load_dd10_pattern();
    push_dd10_pattern();
    run_poly(10, 1'b0, 0, 128, -1);
  endtask

  task automatic test_dd10_gaps();
    load_dd10_pattern();
    push_dd10_pattern();
    run_poly(10, 1'b1, 0, 128, -1);
  endtask

  task automatic test_reset_mid_run();
    for (int w = 0; w < 160; w++) words[w] = 16'($urandom);
    run_poly(10, 1'b0, 30, 0, -1);
    reset10 = 1'b1;
    #1;
    checks++;
    if (ifc10.status !== 4'd0 || ifc10.din_ready !== 1'b0 || ifc10.dout_valid !== 1'b0 ||
        ifc10.addr_out !== 7'd0) begin
      errors++;
      $display("FAIL midrun_reset got status=%0d ready=%b valid=%b addr=%0d required 0 0 0 0",
               ifc10.status, ifc10.din_ready, ifc10.dout_valid, ifc10.addr_out);
    end
    q10.delete();
    set_start(10, 1'b0);
    drive(10, 16'h0, 1'b0);
    @(negedge clk);
    reset10 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc10.status !== 4'd0) begin
      errors++;
      $display("FAIL midrun_wait_idle got status=%0d required 0", ifc10.status);
    end
    $display("mid-run reset applied, restarting");
    run_poly(10, 1'b0, 0, 0, -1);
  endtask

  task automatic test_start_drop();
    for (int w = 0; w < 64; w++) words[w] = 16'($urandom);
    run_poly(4, 1'b1, 0, 0, 20);
  endtask

  initial begin
    test_reset();
    test_set_gating();
    test_all_ones_dd4();
    test_pattern_dd4();
    test_dd10_back_to_back();
    test_dd10_gaps();
    test_reset_mid_run();
    test_start_drop();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
